nx_output_capture: RTL and testbench
====================================

# nx_output_capture

Change-capture stage directly downstream of the generated mesh `Top`. It samples the flattened boundary output bus every cycle and records a timestamped entry whenever the bus value differs from the previous cycle. Records are buffered in a small FIFO and drained over a valid/ready interface to the host readback path. Overflow is reported, never silent.

## Interface

Parameters:
- `WIDTH`, 32: width of the flattened mesh output bus being monitored.
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `CYCLE_W`, 16: width of the cycle timestamp; wraps modulo 2^CYCLE_W.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_enable`  in  1  capture enable.
- `i_outputs`  in  WIDTH  mesh boundary outputs, concatenated.
- `o_rec_data`  out  CYCLE_W+WIDTH  FIFO head record, `{cycle, value}`.
- `o_rec_valid`  out  1  FIFO non-empty.
- `i_rec_ready`  in  1  consumer accepts the head record.
- `o_overflow`  out  1  sticky flag: at least one record was dropped.
- `o_dropped`  out  8  saturating count of dropped records.
- `i_clear_ovf`  in  1  clears `o_overflow` and `o_dropped`.
- `o_cycle`  out  CYCLE_W  current timestamp counter.

## Operation

- **FSM states:**
  - IDLE: `i_enable`=0.
  - RUN: capturing.
- **Transitions:**
  - IDLE→RUN on any edge with `i_enable`=1. That edge pushes a baseline record `{0, i_outputs}` unconditionally and sets the cycle counter to 1.
  - RUN→IDLE on any edge with `i_enable`=0. The cycle counter clears to 0. FIFO contents are retained and continue to drain.
- **RUN behaviour:** on each edge, the counter increments (wrap 2^CYCLE_W−1→0). A record `{cycle_q, i_outputs}` is pushed iff `i_outputs` != `prev_q`, where `cycle_q` is the pre-increment counter value. `prev_q` loads `i_outputs` on every enabled edge, including the baseline edge.
- **Pop:** occurs when `o_rec_valid` && `i_rec_ready`. `o_rec_data` is the head entry, driven combinationally from FIFO storage. It is held stable while `o_rec_valid`=1 and `i_rec_ready`=0.
- **Push and pop on the same edge:**
  - Both are performed.
  - When full, the pop frees the slot, so the push succeeds and nothing is dropped.
  - When empty, the pushed record becomes visible on the following cycle, never in the same cycle.
- **Push when full with no pop:**
  - The record is discarded and FIFO contents are unchanged.
  - `o_overflow` is set.
  - `o_dropped` increments, saturating at 255.
- **`i_clear_ovf`:**
  - Clears both `o_overflow` and `o_dropped` on that edge.
  - If a drop occurs on the same edge, the drop wins: the flag ends at 1 and the count at 1.
- **Occupancy:** an explicit count of width log2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.

## Timing

- **Reset values (`rst`=0, asynchronous):**
  - FSM = IDLE.
  - `o_cycle`=0, `prev_q`=0.
  - FIFO empty, so `o_rec_valid`=0.
  - `o_rec_data`=0 (storage cleared).
  - `o_overflow`=0, `o_dropped`=0.
- **Reset asserted mid-operation:** all buffered records are lost and the state above applies immediately. Capture restarts with a baseline record on the first enabled edge after `rst` deasserts.
- **Latency:** a change present on `i_outputs` before edge N produces `o_rec_valid`=1 after edge N, provided the FIFO was empty.
- **Throughput:** one push and one pop per cycle sustained.
- **Combinational paths:** there are none from inputs to outputs, except `i_rec_ready`→internal pop. `o_rec_valid` and `o_rec_data` depend only on registered state.

## Test plan

- **Baseline and single change:** reset, then `i_enable`=1 with `i_outputs`=0x5 held for 3 edges, then 0x7.
  - Required: exactly two records, `{0,0x5}` and `{3,0x7}`.
  - `i_rec_ready`=1 throughout.
- **Backpressure/full:** DEPTH=8, `i_rec_ready`=0, `i_outputs` toggling every cycle for 12 edges.
  - Required: 8 records retained (cycles 0..7), `o_overflow`=1, `o_dropped`=4.
  - Then drain with ready=1: exactly those 8 records, in order.
- **Full with simultaneous pop:** FIFO full, `i_rec_ready`=1, change present on the same edge.
  - Required: no drop, occupancy stays 8, `o_dropped` unchanged.
- **Clear vs drop collision:** `o_dropped`=5, then assert `i_clear_ovf` on the same edge as a full-FIFO drop.
  - Required: `o_overflow`=1, `o_dropped`=1.
  - A later clear with no drop gives 0 and 0.
- **Timestamp wrap:** CYCLE_W=4, continuous changes.
  - Required: record timestamps run 0..15 then 0, 1, ….
  - A disable/enable sequence restarts with a baseline record at cycle 0.
- **Async reset mid-run:** 3 records buffered, `rst` pulsed low between edges.
  - Required: `o_rec_valid` drops immediately, with no clock edge needed.
  - After release and enable, the first record is a baseline with timestamp 0.

Source files
------------

// File: rtl/nx_output_capture.sv
// Change-capture stage for the mesh boundary bus: timestamps every value change
// into a small FIFO drained over valid/ready, with sticky overflow reporting.
module nx_output_capture #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int CYCLE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_enable,
    input  logic [WIDTH-1:0]           i_outputs,
    output logic [CYCLE_W+WIDTH-1:0]   o_rec_data,
    output logic                       o_rec_valid,
    input  logic                       i_rec_ready,
    output logic                       o_overflow,
    output logic [7:0]                 o_dropped,
    input  logic                       i_clear_ovf,
    output logic [CYCLE_W-1:0]         o_cycle
);

    // state   | meaning
    // IDLE    | capture disabled, counter held at 0
    // RUN     | capturing changes, counter advancing each edge
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = CYCLE_W + WIDTH;

    logic [0:0]         state_q, state_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [WIDTH-1:0]   prev_q;
    logic [RW-1:0]      mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;

    logic               push, pop, full, wr_en, drop;
    logic [RW-1:0]      push_rec;

    always_comb begin
        state_d  = state_q;
        cycle_d  = cycle_q;
        push     = 1'b0;
        push_rec = {cycle_q, i_outputs};
        if (!i_enable) begin
            state_d = ST_IDLE;
            cycle_d = '0;
        end else if (state_q == ST_IDLE) begin
            // Entry edge always records a baseline stamped at cycle 0.
            state_d  = ST_RUN;
            push     = 1'b1;
            push_rec = {{CYCLE_W{1'b0}}, i_outputs};
            cycle_d  = CYCLE_W'(1);
        end else begin
            push    = (i_outputs != prev_q);
            cycle_d = cycle_q + CYCLE_W'(1);
        end
    end

    assign o_rec_valid = (count_q != '0);
    assign o_rec_data  = mem_q[rd_ptr_q];
    assign o_cycle     = cycle_q;

    assign full  = (count_q == CW'(DEPTH));
    assign pop   = o_rec_valid && i_rec_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cycle_q <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            if (i_enable) begin
                prev_q <= i_outputs;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= push_rec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A drop on the same edge as a clear wins: flag stays set, count restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_overflow <= 1'b0;
            o_dropped  <= '0;
        end else if (drop) begin
            o_overflow <= 1'b1;
            if (i_clear_ovf) begin
                o_dropped <= 8'd1;
            end else if (o_dropped != 8'hFF) begin
                o_dropped <= o_dropped + 8'd1;
            end
        end else if (i_clear_ovf) begin
            o_overflow <= 1'b0;
            o_dropped  <= '0;
        end
    end

endmodule

// File: tb/tb_nx_output_capture.sv
// Bench for nx_output_capture: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the capture rules.
module tb_nx_output_capture;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int CYCLE_W = 4;
    localparam int RW      = CYCLE_W + WIDTH;

    logic               clk;
    logic               rst;
    logic               enable;
    logic [WIDTH-1:0]   outputs;
    logic [RW-1:0]      rec_data;
    logic               rec_valid;
    logic               rec_ready;
    logic               overflow;
    logic [7:0]         dropped;
    logic               clear_ovf;
    logic [CYCLE_W-1:0] cycle;

    nx_output_capture #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .CYCLE_W (CYCLE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (enable),
        .i_outputs   (outputs),
        .o_rec_data  (rec_data),
        .o_rec_valid (rec_valid),
        .i_rec_ready (rec_ready),
        .o_overflow  (overflow),
        .o_dropped   (dropped),
        .i_clear_ovf (clear_ovf),
        .o_cycle     (cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0]      mq[$];
    logic [RW-1:0]      dut_log[$];
    logic [CYCLE_W-1:0] m_cycle;
    logic [WIDTH-1:0]   m_prev;
    bit                 m_run;
    bit                 m_ovf;
    int                 m_dropped;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_cycle   = '0;
        m_prev    = '0;
        m_run     = 1'b0;
        m_ovf     = 1'b0;
        m_dropped = 0;
    endtask

    // Next model state from the inputs presented before the coming edge.
    task automatic model_edge();
        bit            do_pop, do_push, do_drop;
        logic [RW-1:0] rec;
        do_pop  = (mq.size() > 0) && rec_ready;
        do_push = 1'b0;
        do_drop = 1'b0;
        rec     = '0;
        if (enable) begin
            if (!m_run) begin
                do_push = 1'b1;
                rec     = {{CYCLE_W{1'b0}}, outputs};
            end else if (outputs != m_prev) begin
                do_push = 1'b1;
                rec     = {m_cycle, outputs};
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(rec);
            else do_drop = 1'b1;
        end
        if (do_drop) begin
            m_ovf     = 1'b1;
            m_dropped = clear_ovf ? 1 : ((m_dropped < 255) ? m_dropped + 1 : 255);
        end else if (clear_ovf) begin
            m_ovf     = 1'b0;
            m_dropped = 0;
        end
        if (!enable)     m_cycle = '0;
        else if (!m_run) m_cycle = CYCLE_W'(1);
        else             m_cycle = m_cycle + CYCLE_W'(1);
        if (enable) m_prev = outputs;
        m_run = enable;
    endtask

    task automatic check_state();
        chk("valid", rec_valid, (mq.size() != 0));
        if (mq.size() != 0) chk("head", rec_data, mq[0]);
        chk("ovf", overflow, m_ovf);
        chk("dropped", dropped, m_dropped);
        chk("cycle", cycle, m_cycle);
    endtask

    task automatic tick();
        if (rec_valid && rec_ready) dut_log.push_back(rec_data);
        model_edge();
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_valid", rec_valid, 0);
        chk("rst_data", rec_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_cycle", cycle, 0);
        model_clear();
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        enable    = 1'b0;
        outputs   = '0;
        rec_ready = 1'b0;
        clear_ovf = 1'b0;
        model_clear();
        do_reset();

        // baseline and single change
        dut_log.delete();
        enable = 1'b1; rec_ready = 1'b1; outputs = 32'h5;
        repeat (3) tick();
        outputs = 32'h7;
        repeat (4) tick();
        chk("base_n", dut_log.size(), 2);
        if (dut_log.size() >= 2) begin
            chk("base_rec0", dut_log[0], {4'd0, 32'h5});
            chk("base_rec1", dut_log[1], {4'd3, 32'h7});
        end
        enable = 1'b0;
        tick();

        // backpressure and overflow
        do_reset();
        rec_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            outputs = WIDTH'(i + 'h100);
            tick();
        end
        chk("bp_ovf", overflow, 1);
        chk("bp_dropped", dropped, 4);
        dut_log.delete();
        enable = 1'b0; rec_ready = 1'b1;
        repeat (10) tick();
        chk("bp_n", dut_log.size(), 8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++)
            chk("bp_rec", dut_log[i], {CYCLE_W'(i), WIDTH'(i + 'h100)});

        // full with simultaneous pop
        do_reset();
        rec_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            outputs = WIDTH'(i + 'h200);
            tick();
        end
        dut_log.delete();
        rec_ready = 1'b1; outputs = 32'h300;
        tick();
        chk("fp_ovf", overflow, 0);
        chk("fp_dropped", dropped, 0);
        enable = 1'b0;
        repeat (10) tick();
        chk("fp_n", dut_log.size(), 9);
        if (dut_log.size() == 9) chk("fp_last", dut_log[8], {4'd8, 32'h300});

        // clear vs drop collision
        do_reset();
        rec_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 13; i++) begin
            outputs = WIDTH'(i + 'h400);
            tick();
        end
        chk("cd_dropped5", dropped, 5);
        clear_ovf = 1'b1; outputs = 32'h500;
        tick();
        chk("cd_ovf_win", overflow, 1);
        chk("cd_dropped_win", dropped, 1);
        tick();
        chk("cd_ovf_clr", overflow, 0);
        chk("cd_dropped_clr", dropped, 0);
        clear_ovf = 1'b0;

        // timestamp wrap
        do_reset();
        dut_log.delete();
        rec_ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            outputs = WIDTH'(i + 'h600);
            tick();
        end
        repeat (2) tick();
        chk("wr_n", dut_log.size(), 20);
        for (int i = 0; i < 20 && i < dut_log.size(); i++)
            chk("wr_ts", dut_log[i][RW-1:WIDTH], i % 16);
        dut_log.delete();
        enable = 1'b0;
        tick();
        enable = 1'b1; outputs = 32'h777;
        repeat (2) tick();
        chk("wr_restart_n", dut_log.size(), 1);
        if (dut_log.size() == 1) chk("wr_restart", dut_log[0], {4'd0, 32'h777});

        // async reset mid-run
        do_reset();
        rec_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            outputs = WIDTH'(i + 'h800);
            tick();
        end
        chk("ar_valid_pre", rec_valid, 1);
        do_reset();
        outputs = 32'h900;
        tick();
        chk("ar_valid_post", rec_valid, 1);
        chk("ar_base", rec_data, {4'd0, 32'h900});

        // saturation of the drop counter
        do_reset();
        rec_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 270; i++) begin
            outputs = WIDTH'(i + 'h1000);
            tick();
        end
        chk("sat_dropped", dropped, 255);

        // random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            enable    = ($urandom_range(0, 19) != 0);
            outputs   = ($urandom_range(0, 9) == 0) ? $urandom() : WIDTH'($urandom_range(0, 3));
            rec_ready = ($urandom_range(0, 2) == 0);
            clear_ovf = ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
